// File: rtl/uart_rx_fifo_if.sv
//----------------------------------------------------------------------------
// uart_rx_fifo_if : write/read/status bundle between host logic and the RX FIFO
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface uart_rx_fifo_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          almost_full;
  logic          overflow;
  logic          ovf_clr;

  modport master (
    output wr_en, wr_data, rd_en, ovf_clr,
    input  rd_data, empty, full, count, almost_full, overflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, ovf_clr,
    output rd_data, empty, full, count, almost_full, overflow
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
//----------------------------------------------------------------------------
// uart_rx_fifo : FWFT byte buffer behind the UART receiver with sticky overflow
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int AF_LEVEL = 12
) (
  input  wire logic       clk,
  input  wire logic       reset,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_AF      = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   C_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;

  logic w_empty, w_full, w_wr_acc, w_rd_acc, w_drop;

  assign w_empty  = (count_q == '0);
  assign w_full   = (count_q == C_DEPTH);
  assign w_rd_acc = bus.rd_en && !w_empty;
  // At full, a same-cycle pop frees the slot the write lands in.
  assign w_wr_acc = bus.wr_en && (!w_full || bus.rd_en);
  assign w_drop   = bus.wr_en && w_full && !bus.rd_en;

  always_comb begin
    count_d = count_q;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (w_wr_acc) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (w_rd_acc) rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      if (w_drop)
        overflow_q <= 1'b1;
      else if (bus.ovf_clr)
        overflow_q <= 1'b0;
    end
  end

  // Storage is deliberately not reset; only pointers and count define content.
  always_ff @(posedge clk) begin
    if (reset && w_wr_acc) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data     = w_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.count       = count_q;
  assign bus.almost_full = (count_q >= C_AF);
  assign bus.overflow    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
//----------------------------------------------------------------------------
// tb_uart_rx_fifo : directed scoreboard bench for uart_rx_fifo
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AFL   = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart_rx_fifo_if #(.AW(AW)) bus ();

  uart_rx_fifo #(.DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AFL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb_q [$];
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [7:0] head;
    n = sb_q.size();
    head = (n > 0) ? sb_q[0] : 8'h00;
    chk({tag, ".count"}, 32'(bus.count), 32'(n));
    chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AFL));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".rd_data"}, 32'(bus.rd_data), 32'(head));
  endtask

  // One clock cycle of stimulus; expected pops are compared before the edge.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    bit was_full, rd_acc, wr_acc, drop;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    bus.ovf_clr = clr;
    was_full = (sb_q.size() == DEPTH);
    rd_acc   = rd && (sb_q.size() > 0);
    wr_acc   = wr && (!was_full || rd);
    drop     = wr && was_full && !rd;
    #1;
    if (rd_acc) chk("pop", 32'(bus.rd_data), 32'(sb_q[0]));
    @(posedge clk);
    #1;
    if (rd_acc) void'(sb_q.pop_front());
    if (wr_acc) sb_q.push_back(d);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h5A;
    bus.rd_en   = 1'b0;
    bus.ovf_clr = 1'b0;

    // Reset held 3 cycles with a write strobe active
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
    check_all("reset");

    // Single byte
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check_all("single_wr");
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_all("single_rd");

    // Read while empty is ignored
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_all("rd_empty");

    // Fill, watching almost_full threshold, then a dropped write
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      check_all("fill");
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check_all("overflow_set");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_all("drain");
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_all("ovf_clr");

    // Simultaneous write and read at full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check_all("full_wr_rd");
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_all("drain2");

    // Empty with write and read together: write only
    step(1'b1, 8'h3C, 1'b1, 1'b0);
    check_all("empty_wr_rd");
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around with delayed reads
    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h10 + i), (i >= 3), 1'b0);
    check_all("wrap");
    while (sb_q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_all("wrap_drain");

    // Overflow set beats clear, then clear alone
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    check_all("ovf_again");
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    check_all("ovf_set_wins");
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_all("ovf_clear");

    // Reset mid-operation with 5 bytes buffered
    while (sb_q.size() > 5) step(1'b0, 8'h00, 1'b1, 1'b0);
    check_all("count5");
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h99;
    bus.rd_en   = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
    check_all("mid_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver delivers with its one-cycle done pulse and holds it until the host logic pops it. This decouples the serial line rate from the consumer. It reports fill level, almost-full and a sticky overflow flag so lost bytes are never silent.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, 4, address width; must equal log2(DEPTH).
- AF_LEVEL, 12, `almost_full` asserts when `count >= AF_LEVEL`; range 1..DEPTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low; clock clk.
- wr_en  input  1  write strobe, connected to the receiver's done pulse; each high cycle is one write.
- wr_data  input  8  byte to write, connected to the receiver's data output; sampled only when `wr_en`=1.
- rd_en  input  1  pop request; removes the head byte at the clock edge.
- rd_data  output  8  head byte in first-word-fall-through mode; forced to 8'h00 whenever `empty`=1.
- empty  output  1  high when `count`==0.
- full  output  1  high when `count`==DEPTH.
- count  output  AW+1  number of stored bytes, 0..DEPTH.
- almost_full  output  1  high when `count >= AF_LEVEL`.
- overflow  output  1  sticky; set when a write is dropped.
- ovf_clr  input  1  clears `overflow` (single-cycle pulse or level).

## Operation
- Storage is a DEPTH x 8 array with `wr_ptr` and `rd_ptr` (AW bits each) and a separate `count` register (AW+1 bits).
- Pointers wrap modulo DEPTH. Natural binary rollover is required; no compare-and-clear.
- Accepted write (`wr_en` and not full, or `wr_en` and full and `rd_en`): `mem[wr_ptr] <= wr_data`, then `wr_ptr` increments.
- Accepted read (`rd_en` and not empty): `rd_ptr` increments.
- Count update rules:
  - Write only: `count` +1.
  - Read only: `count` -1.
  - Both accepted in the same cycle: `count` is unchanged.
- Full and `wr_en` with no `rd_en`: the write is dropped, memory and pointers are unchanged, and `overflow` <= 1.
- Full and `wr_en` and `rd_en` together: the read and the write both succeed, and `overflow` is not set.
- Empty and `rd_en`: ignored. No pointer move, no flag.
- Empty and `wr_en` and `rd_en` together: the write is accepted and the read is ignored. `count` becomes 1. There is no bypass.
- `overflow` priority: a set in the same cycle as `ovf_clr` wins, so `overflow` stays 1.
- `rd_data` is driven combinationally from `mem[rd_ptr]` and gated to 0 when empty.
- The flags `empty`, `full` and `almost_full` are decoded combinationally from the registered `count`.
- Reset (`reset`=0 at an edge):
  - `wr_ptr`, `rd_ptr` and `count` go to 0, and `overflow` goes to 0.
  - Memory contents are not cleared.
  - Reset overrides any `wr_en`/`rd_en` in the same cycle.
  - Reset in the middle of operation discards all buffered bytes.

## Timing
- Reset values of outputs: `rd_data`=8'h00, `empty`=1, `full`=0, `count`=0, `almost_full`=0, `overflow`=0.
- Write latency: a byte written at edge N gives `empty`=0, `count`+1 and valid `rd_data` from cycle N+1 onward, i.e. one cycle.
- Read: `rd_data` is valid while `empty`=0. Asserting `rd_en` consumes that byte at the edge. The next byte, or 8'h00 if now empty, appears in the following cycle.
- Back-to-back `rd_en` every cycle drains one byte per cycle. Sustained simultaneous write and read every cycle keeps `count` constant.
- `overflow` rises one cycle after the dropped write edge. It falls one cycle after the `ovf_clr` edge.
- Receiver done pulses arrive at most once per 160 `s_tick`s. The FIFO imposes no minimum gap between writes and accepts one per cycle.

## Test plan
- Reset behaviour: hold `reset`=0 for 3 cycles while `wr_en`=1 -> `count`=0, `empty`=1, `rd_data`=8'h00, `overflow`=0 after release.
- Single byte: write 8'hA5 at one edge -> next cycle `rd_data`=8'hA5, `count`=1. Pulse `rd_en` -> next cycle `empty`=1, `rd_data`=8'h00.
- Fill and overflow: write 8'h00..8'h0F (16 bytes), then write 8'hFF -> `full`=1, `count`=16, `almost_full` high from `count`=12, `overflow`=1. Draining returns 8'h00..8'h0F in order; 8'hFF never appears.
- Simultaneous at full: full with head 8'h00, then one cycle with `wr_en`=1 (8'h77) and `rd_en`=1 -> `count` stays 16, `overflow` stays 0, 8'h77 is read last.
- Wrap-around: 40 cycles of write 8'h10+i paired with delayed reads -> output sequence is exactly 8'h10..8'h37 with no loss across pointer wraps.
- Overflow clear and reset mid-operation: with `overflow`=1, assert `ovf_clr` together with a dropped write -> `overflow` stays 1; `ovf_clr` alone -> 0. With `count`=5, assert `reset` -> `count`=0, `empty`=1 the next cycle.
